// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the GCD unit.
// Accepts an operand pair, iterates compare/subtract through an external
// registered subtractor stage, and returns the GCD over a valid/ready handshake.
// Optional build macro: GCD_ITER_CNT_EN adds a saturating iteration counter
// output (iter_cnt) that counts subtract iterations for the current operation.
module gcd_controller #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic [1:0]   sub_cmd,
    output logic [W-1:0] sub_a,
    output logic [W-1:0] sub_b,
    input  logic [W-1:0] sub_aout,
    input  logic [W-1:0] sub_bout
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [15:0]  iter_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CMD_A_GT_B = 2'b00;
    localparam logic [1:0] CMD_A_LT_B = 2'b01;
    localparam logic [1:0] CMD_HOLD   = 2'b10;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [W-1:0]   gcd_reg, gcd_next;
    logic           accept;

    // State and working registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            gcd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            gcd_reg   <= gcd_next;
        end
    end

    // Next-state, working-register updates and subtractor command.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        gcd_next   = gcd_reg;
        sub_cmd    = CMD_HOLD;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    a_next     = in_a;
                    b_next     = in_b;
                    state_next = S_CMP;
                end
            end
            S_CMP: begin
                // Zero operands short-circuit before the magnitude compare.
                if ((a_reg == '0) || (b_reg == '0)) begin
                    gcd_next   = a_reg | b_reg;
                    state_next = S_DONE;
                end else if (a_reg == b_reg) begin
                    gcd_next   = a_reg;
                    state_next = S_DONE;
                end else if (a_reg > b_reg) begin
                    sub_cmd    = CMD_A_GT_B;
                    state_next = S_WAIT;
                end else begin
                    sub_cmd    = CMD_A_LT_B;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Subtractor output registered on the CMP->WAIT edge is valid now.
                a_next     = sub_aout;
                b_next     = sub_bout;
                state_next = S_CMP;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign sub_a   = a_reg;
    assign sub_b   = b_reg;
    assign out_gcd = gcd_reg;

`ifdef GCD_ITER_CNT_EN
    logic [15:0] cnt_reg;
    logic        enter_wait;

    assign enter_wait = (state_reg == S_CMP) && (state_next == S_WAIT);

    // Iteration counter: cleared per accepted pair, saturating increment per subtract.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            cnt_reg <= '0;
        end else if (enter_wait && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign iter_cnt = cnt_reg;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
